// File: rtl/axi_write_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_write_slave
//  Purpose  : AXI4 write-channel responder. Accepts one AW/W burst at a time,
//             forwards each data beat to a simple per-beat backend, and returns
//             one B response per burst. No outstanding-transaction queue.
//  Ports    : clk, rst          - clock (rising edge), async active-high reset
//             s_axi_aw*         - write address channel (slave side)
//             s_axi_w*          - write data channel (slave side)
//             s_axi_b*          - write response channel (slave side)
//             write_*           - backend beat request / handshake
//  Revision : 1.0  initial release
// ============================================================================
module axi_write_slave #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDW-1:0]    s_axi_awid,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [IDW-1:0]    s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              write_valid,
  output logic [AW-1:0]     write_addr,
  output logic [DW-1:0]     write_data,
  output logic [DW/8-1:0]   write_strb,
  input  logic              write_ready
);

  localparam int SW      = DW / 8;
  localparam int MAXSIZE = $clog2(SW);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  id_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            err_q;

  logic            beat;
  logic            last_beat;
  logic            aw_err;
  logic [AW-1:0]   bytes;
  logic [AW-1:0]   wrap_mask;
  logic [AW-1:0]   addr_incr;
  logic [AW-1:0]   addr_wrap;
  logic [AW-1:0]   addr_d;

  // Only 2/4/8/16-beat wrapping bursts are legal.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Protocol errors detectable from the address phase alone.
  assign aw_err = (s_axi_awburst == BURST_RSVD) ||
                  (s_axi_awsize > 3'(MAXSIZE)) ||
                  ((s_axi_awburst == BURST_WRAP) && !wrap_len_ok(s_axi_awlen));

  // Next beat address. An illegal-length WRAP falls back to INCR stepping.
  always_comb begin
    bytes     = AW'(1) << size_q;
    addr_incr = (addr_q & ~(bytes - AW'(1))) + bytes;
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    addr_wrap = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
    addr_d    = addr_incr;
    if (burst_q == BURST_FIXED) begin
      addr_d = addr_q;
    end else if ((burst_q == BURST_WRAP) && wrap_len_ok(len_q)) begin
      addr_d = addr_wrap;
    end
  end

  // Channel outputs decode only state registers plus W/backend inputs.
  assign s_axi_awready = (state_q == IDLE);
  assign s_axi_wready  = (state_q == DATA) && write_ready;
  assign write_valid   = (state_q == DATA) && s_axi_wvalid;
  assign write_addr    = addr_q;
  assign write_data    = s_axi_wdata;
  assign write_strb    = ((state_q == DATA) && !err_q) ? s_axi_wstrb : {SW{1'b0}};
  assign s_axi_bvalid  = (state_q == RESP);
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;

  assign beat      = (state_q == DATA) && s_axi_wvalid && write_ready;
  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_axi_awvalid) begin
            id_q    <= s_axi_awid;
            addr_q  <= s_axi_awaddr;
            len_q   <= s_axi_awlen;
            size_q  <= s_axi_awsize;
            burst_q <= s_axi_awburst;
            cnt_q   <= '0;
            err_q   <= aw_err;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            // The beat count, not wlast, terminates the burst; a misplaced
            // wlast only flags the error.
            if (s_axi_wlast != last_beat) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              state_q <= RESP;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        RESP: begin
          if (s_axi_bready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_write_slave
//  Purpose  : Directed self-checking bench for axi_write_slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_write_slave;

  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic            clk;
  logic            rst;
  logic [IDW-1:0]  s_axi_awid;
  logic [AW-1:0]   s_axi_awaddr;
  logic [7:0]      s_axi_awlen;
  logic [2:0]      s_axi_awsize;
  logic [1:0]      s_axi_awburst;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic            s_axi_wlast;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [IDW-1:0]  s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic            write_valid;
  logic [AW-1:0]   write_addr;
  logic [DW-1:0]   write_data;
  logic [DW/8-1:0] write_strb;
  logic            write_ready;

  int vectors;
  int miscompares;

  axi_write_slave #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .write_valid   (write_valid),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .write_strb    (write_strb),
    .write_ready   (write_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an AW request for one cycle; it is accepted on the next rising edge.
  task automatic do_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    @(negedge clk);
    s_axi_awvalid = 1'b1;
    s_axi_awid    = id;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = size;
    s_axi_awburst = burst;
    #1 chk("aw_ready", 64'(s_axi_awready), 64'd1);
  endtask

  // One W beat with the backend ready; checks the combinational backend view.
  task automatic do_beat(input logic [DW-1:0] data, input logic [7:0] strb, input logic last,
                         input logic [AW-1:0] exp_addr, input logic [7:0] exp_strb);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wlast   = last;
    write_ready   = 1'b1;
    #1;
    chk("beat_wready", 64'(s_axi_wready), 64'd1);
    chk("beat_wvalid", 64'(write_valid), 64'd1);
    chk("beat_addr", 64'(write_addr), 64'(exp_addr));
    chk("beat_strb", 64'(write_strb), 64'(exp_strb));
    chk("beat_data", write_data, data);
    chk("beat_awready", 64'(s_axi_awready), 64'd0);
  endtask

  // Expect B valid the cycle after the last beat, accept it, then expect IDLE.
  task automatic do_resp(input logic [IDW-1:0] id, input logic [1:0] resp);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    s_axi_bready = 1'b1;
    #1;
    chk("resp_bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("resp_bid", 64'(s_axi_bid), 64'(id));
    chk("resp_bresp", 64'(s_axi_bresp), 64'(resp));
    chk("resp_wready", 64'(s_axi_wready), 64'd0);
    @(negedge clk);
    s_axi_bready = 1'b0;
    #1;
    chk("post_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("post_awready", 64'(s_axi_awready), 64'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_awready", 64'(s_axi_awready), 64'd1);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
    chk("rst_bid", 64'(s_axi_bid), 64'd0);
    chk("rst_wvalid", 64'(write_valid), 64'd0);
    chk("rst_waddr", 64'(write_addr), 64'd0);
    chk("rst_wstrb", 64'(write_strb), 64'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    s_axi_awid    = '0;
    s_axi_awaddr  = '0;
    s_axi_awlen   = '0;
    s_axi_awsize  = '0;
    s_axi_awburst = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wlast   = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    write_ready   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_wready", 64'(s_axi_wready), 64'd0);

    // INCR 0x1000 len 3 size 3
    do_aw(12'h0A1, 32'h1000, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++)
      do_beat(64'h1111_0000_0000_0000 + 64'(i), 8'hFF, (i == 3), 32'h1000 + 32'(8 * i), 8'hFF);
    do_resp(12'h0A1, 2'b00);

    // WRAP 0x1018 len 3 size 3: 0x1018, 0x1000, 0x1008, 0x1010
    do_aw(12'h0A2, 32'h1018, 8'd3, 3'd3, 2'b10);
    do_beat(64'h20, 8'hF0, 1'b0, 32'h1018, 8'hF0);
    do_beat(64'h21, 8'h0F, 1'b0, 32'h1000, 8'h0F);
    do_beat(64'h22, 8'hFF, 1'b0, 32'h1008, 8'hFF);
    do_beat(64'h23, 8'h3C, 1'b1, 32'h1010, 8'h3C);
    do_resp(12'h0A2, 2'b00);

    // FIXED 0x2004 len 2 size 2 with backend stalling every other cycle
    do_aw(12'h123, 32'h2004, 8'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b1;
      s_axi_wdata   = 64'h3000 + 64'(i);
      s_axi_wstrb   = 8'h0F;
      s_axi_wlast   = (i == 2);
      write_ready   = 1'b0;
      #1;
      chk("stall_wready", 64'(s_axi_wready), 64'd0);
      chk("stall_wvalid", 64'(write_valid), 64'd1);
      chk("stall_addr", 64'(write_addr), 64'h2004);
      chk("stall_bvalid", 64'(s_axi_bvalid), 64'd0);
      @(negedge clk);
      write_ready = 1'b1;
      #1;
      chk("fixed_wready", 64'(s_axi_wready), 64'd1);
      chk("fixed_addr", 64'(write_addr), 64'h2004);
      chk("fixed_strb", 64'(write_strb), 64'h0F);
    end
    do_resp(12'h123, 2'b00);

    // INCR len 3, wlast on beat 1: later strobes suppressed, SLVERR
    do_aw(12'h0A4, 32'h1000, 8'd3, 3'd3, 2'b01);
    do_beat(64'h40, 8'hFF, 1'b0, 32'h1000, 8'hFF);
    do_beat(64'h41, 8'hFF, 1'b1, 32'h1008, 8'hFF);
    do_beat(64'h42, 8'hFF, 1'b0, 32'h1010, 8'h00);
    do_beat(64'h43, 8'hFF, 1'b0, 32'h1018, 8'h00);
    do_resp(12'h0A4, 2'b10);

    // awsize 4 exceeds the 8-byte bus: no strobes, 16-byte steps, SLVERR
    do_aw(12'h0A5, 32'h3000, 8'd1, 3'd4, 2'b01);
    do_beat(64'h50, 8'hFF, 1'b0, 32'h3000, 8'h00);
    do_beat(64'h51, 8'hFF, 1'b1, 32'h3010, 8'h00);
    do_resp(12'h0A5, 2'b10);

    // WRAP with illegal len 2: INCR addressing, SLVERR
    do_aw(12'h0A6, 32'h4008, 8'd2, 3'd3, 2'b10);
    do_beat(64'h60, 8'hFF, 1'b0, 32'h4008, 8'h00);
    do_beat(64'h61, 8'hFF, 1'b0, 32'h4010, 8'h00);
    do_beat(64'h62, 8'hFF, 1'b1, 32'h4018, 8'h00);
    do_resp(12'h0A6, 2'b10);

    // bready held low 5 cycles while a new AW is offered
    do_aw(12'h0A7, 32'h6000, 8'd0, 3'd3, 2'b01);
    do_beat(64'h70, 8'hFF, 1'b1, 32'h6000, 8'hFF);
    @(negedge clk);
    s_axi_wvalid  = 1'b0;
    s_axi_wlast   = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_awvalid = 1'b1;
    s_axi_awid    = 12'h0B8;
    s_axi_awaddr  = 32'h7000;
    s_axi_awlen   = 8'd0;
    s_axi_awsize  = 3'd3;
    s_axi_awburst = 2'b01;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("hold_bvalid", 64'(s_axi_bvalid), 64'd1);
      chk("hold_bid", 64'(s_axi_bid), 64'h0A7);
      chk("hold_bresp", 64'(s_axi_bresp), 64'd0);
      chk("hold_awready", 64'(s_axi_awready), 64'd0);
    end
    @(negedge clk);
    s_axi_bready = 1'b1;
    #1 chk("hold_bhs", 64'(s_axi_bvalid), 64'd1);
    @(negedge clk);
    s_axi_bready = 1'b0;
    #1;
    chk("after_b_awready", 64'(s_axi_awready), 64'd1);
    chk("after_b_bvalid", 64'(s_axi_bvalid), 64'd0);
    do_beat(64'h80, 8'hFF, 1'b1, 32'h7000, 8'hFF);
    do_resp(12'h0B8, 2'b00);

    // Reset pulsed during beat 2 of a len 7 burst
    do_aw(12'h0C9, 32'h5000, 8'd7, 3'd3, 2'b01);
    do_beat(64'h90, 8'hFF, 1'b0, 32'h5000, 8'hFF);
    @(negedge clk);
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 64'h91;
    s_axi_wlast  = 1'b0;
    #1 chk("pre_rst_addr", 64'(write_addr), 64'h5008);
    rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    rst          = 1'b0;
    s_axi_wvalid = 1'b0;
    #1;
    chk("post_rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("post_rst_awready", 64'(s_axi_awready), 64'd1);
    do_aw(12'h0DA, 32'h5100, 8'd0, 3'd3, 2'b01);
    do_beat(64'hA0, 8'hFF, 1'b1, 32'h5100, 8'hFF);
    do_resp(12'h0DA, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_write_slave.md
# axi_write_slave

AXI4 write-channel responder: accepts one write burst at a time on AW/W, issues one backend write per data beat, and returns a single B response. It is the write-direction counterpart of the read bridge pair and sits between an AXI master and a simple per-beat memory/register backend. Bursts are processed strictly in order with no outstanding-transaction queue.

## Interface
- IDW, 12, AXI ID width
- AW, 32, address width
- DW, 64, data width; strobe width DW/8

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_axi_awid  in  IDW  write address ID
- s_axi_awaddr  in  AW  burst start address
- s_axi_awlen  in  8  beats minus one
- s_axi_awsize  in  3  log2(bytes per beat)
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DW  write data
- s_axi_wstrb  in  DW/8  byte strobes
- s_axi_wlast  in  1  last beat marker
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  IDW  response ID
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- write_valid  out  1  backend beat request
- write_addr  out  AW  backend beat address
- write_data  out  DW  backend beat data (= s_axi_wdata)
- write_strb  out  DW/8  backend byte enables
- write_ready  in  1  backend accepts beat

## Operation
- FSM states IDLE, DATA, RESP; rst forces IDLE.
- IDLE: awready=1. AW handshake (awvalid&awready) latches id, addr, len, size, burst; beat counter cleared; err cleared then set if awburst==11 or awsize>log2(DW/8); go DATA.
- DATA: wready = write_ready; write_valid = wvalid; write_addr = current beat address; write_strb = err ? 0 : wstrb. Beat accepted when wvalid&wready (same cycle backend accepts).
- Per accepted beat: if wlast != (counter==len), set err. If counter==len go RESP, else counter+1 and advance address.
- Address advance, bytes = 1<<size: FIXED: unchanged. INCR/reserved: (addr & ~(bytes-1)) + bytes, modulo 2^AW. WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+bytes) & mask). WRAP with len not in {1,3,7,15} sets err, addresses computed as INCR. No 4 KB boundary check.
- RESP: bvalid=1, bid=latched id, bresp = err ? 10 : 00; held stable until bready; on B handshake go IDLE.
- W beats arriving before AW are not accepted (wready=0 outside DATA). AW offered outside IDLE is not accepted (awready=0).

## Timing
- Reset values: awready=1 (state IDLE), wready=0, bvalid=0, bresp=00, bid=0, write_valid=0, write_addr=0, write_strb=0.
- AW handshake in cycle N: wready may assert in N+1.
- Final W handshake in cycle M: bvalid=1 in M+1 (registered).
- B handshake in cycle K: awready=1 in K+1.
- Minimum single-beat transaction: 3 cycles AW-to-next-AW; burst of L+1 beats with no stalls: L+3 cycles.
- write_valid/wready/write_addr/write_strb are combinational from state registers and wvalid/write_ready/wstrb; no combinational path from awvalid or bready to any output.
- Backend stall (write_ready=0) holds wready=0; beat, address and counter unchanged.
- Reset mid-burst: immediate return to IDLE, bvalid and write_valid low, partial burst discarded, no B response issued.

## Test plan
- INCR, addr 0x1000, len 3, size 3, wlast on beat 3, no stalls -> write_addr 0x1000/0x1008/0x1010/0x1018, bvalid one cycle after beat 3, bresp 00, bid echoes awid.
- WRAP, addr 0x1018, len 3, size 3 -> write_addr 0x1018, 0x1000, 0x1008, 0x1010; bresp 00.
- FIXED, addr 0x2004, len 2, size 2, write_ready low on alternate cycles -> three writes all at 0x2004, wready mirrors write_ready, counter stalls correctly.
- INCR len 3 with wlast on beat 1 -> all 4 beats consumed, bresp 10; separately awsize=4 (DW=64) -> write_strb 0 on every beat, bresp 10.
- bready held low 5 cycles in RESP -> bvalid/bid/bresp stable, awready 0 and new awvalid ignored until B handshake; awready 1 next cycle.
- rst pulsed during beat 2 of len 7 burst -> all outputs at reset values next cycle, subsequent len 0 burst completes with bresp 00.
